// File: rtl/lm32_ptw.sv
// Two-level page-table walker for the LM32 data TLB.
// Optional walk timeout is enabled by defining CFG_PTW_TIMEOUT_EN.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   miss_i, miss_vaddr_i    DTLB miss request and faulting address
//   pt_base_i               page-directory base (bits 31:12)
//   ptw_adr_o/cyc_o/stb_o   bus read request (word aligned)
//   ptw_dat_i/ack_i/err_i   bus read response
//   tlb_vaddr_o/paddr_o     fill page addresses, held outside FILL
//   tlb_we_o                one-cycle fill strobe
//   busy_o                  walker not idle
//   fault_o, fault_code_o   one-cycle fault pulse, sticky cause code
module lm32_ptw #(
  parameter int page_size = 4096
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        miss_i,
  input  logic [31:0] miss_vaddr_i,
  input  logic [31:0] pt_base_i,
  output logic [31:0] ptw_adr_o,
  output logic        ptw_cyc_o,
  output logic        ptw_stb_o,
  input  logic [31:0] ptw_dat_i,
  input  logic        ptw_ack_i,
  input  logic        ptw_err_i,
  output logic [31:0] tlb_vaddr_o,
  output logic [31:0] tlb_paddr_o,
  output logic        tlb_we_o,
  output logic        busy_o,
  output logic        fault_o,
  output logic [1:0]  fault_code_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_L1,
    S_L2,
    S_FILL,
    S_FAULT
  } state_t;

  localparam logic [1:0] C_L1  = 2'b01;
  localparam logic [1:0] C_L2  = 2'b10;
  localparam logic [1:0] C_BUS = 2'b11;

  state_t      r_state;
  state_t      w_state_nx;
  logic        r_gap;
  logic        w_gap_nx;
  logic [19:0] r_vpn;
  logic [19:0] r_base;
  logic [19:0] r_l1;
  logic [31:0] r_tlb_v;
  logic [31:0] r_tlb_p;
  logic [1:0]  r_code;
  logic [1:0]  w_code_nx;
  logic        w_start;
  logic        w_l1_ld;
  logic        w_fill_ld;
  logic        w_fault_ld;
  logic        w_cyc;
  logic [31:0] w_adr;
  logic        w_tmo;
  logic        w_unused;

  assign w_unused = ^{miss_vaddr_i[11:0],
                      pt_base_i[11:0],
                      ptw_dat_i[11:1]};

  // r_gap marks the idle bus cycle between the two reads
  assign w_cyc = (r_state == S_L1) ||
                 ((r_state == S_L2) && !r_gap);

  always_comb begin
    w_adr = 32'h0;
    if (r_state == S_L1)
      w_adr = {r_base, r_vpn[19:10], 2'b00};
    else if (w_cyc)
      w_adr = {r_l1, r_vpn[9:0], 2'b00};
  end

`ifdef CFG_PTW_TIMEOUT_EN
  logic [7:0] r_tmo;

  // counts cycles of the current bus request;
  // the 255th unanswered cycle aborts the walk
  assign w_tmo = w_cyc && (r_tmo == 8'hFE);

  always_ff @(posedge clk_i) begin
    if (rst_i)
      r_tmo <= 8'h00;
    else if (w_cyc && !ptw_ack_i &&
             !ptw_err_i && !w_tmo)
      r_tmo <= r_tmo + 8'h01;
    else
      r_tmo <= 8'h00;
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_gap_nx   = r_gap;
    w_code_nx  = r_code;
    w_start    = 1'b0;
    w_l1_ld    = 1'b0;
    w_fill_ld  = 1'b0;
    w_fault_ld = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (miss_i) begin
          w_start    = 1'b1;
          w_state_nx = S_L1;
        end
      end
      S_L1: begin
        if (ptw_err_i || w_tmo) begin
          w_fault_ld = 1'b1;
          w_code_nx  = C_BUS;
          w_state_nx = S_FAULT;
        end else if (ptw_ack_i) begin
          if (ptw_dat_i[0]) begin
            w_l1_ld    = 1'b1;
            w_gap_nx   = 1'b1;
            w_state_nx = S_L2;
          end else begin
            w_fault_ld = 1'b1;
            w_code_nx  = C_L1;
            w_state_nx = S_FAULT;
          end
        end
      end
      S_L2: begin
        if (r_gap) begin
          w_gap_nx = 1'b0;
        end else if (ptw_err_i || w_tmo) begin
          w_fault_ld = 1'b1;
          w_code_nx  = C_BUS;
          w_state_nx = S_FAULT;
        end else if (ptw_ack_i) begin
          if (ptw_dat_i[0]) begin
            w_fill_ld  = 1'b1;
            w_state_nx = S_FILL;
          end else begin
            w_fault_ld = 1'b1;
            w_code_nx  = C_L2;
            w_state_nx = S_FAULT;
          end
        end
      end
      S_FILL:  w_state_nx = S_IDLE;
      S_FAULT: w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_gap   <= 1'b0;
      r_vpn   <= 20'h0;
      r_base  <= 20'h0;
      r_l1    <= 20'h0;
      r_tlb_v <= 32'h0;
      r_tlb_p <= 32'h0;
      r_code  <= 2'b00;
    end else begin
      r_state <= w_state_nx;
      r_gap   <= w_gap_nx;
      if (w_start) begin
        r_vpn  <= miss_vaddr_i[31:12];
        r_base <= pt_base_i[31:12];
      end
      if (w_l1_ld)
        r_l1 <= ptw_dat_i[31:12];
      if (w_fill_ld) begin
        r_tlb_v <= {r_vpn, 12'h000};
        r_tlb_p <= {ptw_dat_i[31:12], 12'h000};
      end
      if (w_fault_ld)
        r_code <= w_code_nx;
    end
  end

  assign ptw_adr_o    = w_adr;
  assign ptw_cyc_o    = w_cyc;
  assign ptw_stb_o    = w_cyc;
  assign tlb_vaddr_o  = r_tlb_v;
  assign tlb_paddr_o  = r_tlb_p;
  assign tlb_we_o     = (r_state == S_FILL);
  assign fault_o      = (r_state == S_FAULT);
  assign busy_o       = (r_state != S_IDLE);
  assign fault_code_o = r_code;

endmodule
